hazard_ctrl: RTL



---
 rtl/cpu_types_pkg.sv | 40 ++++
 rtl/hazard_if.sv | 47 ++++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the hazard controller's state and latch-control encodings.
package cpu_types_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_wen;
        logic idex_flush;
        logic exmem_wen;
        logic exmem_flush;
        logic memwb_wen;
    } latch_ctrl_t;

    localparam latch_ctrl_t CTRL_RUN = '{
        pc_wen: 1'b1, ifid_wen: 1'b1, ifid_flush: 1'b0, idex_wen: 1'b1,
        idex_flush: 1'b0, exmem_wen: 1'b1, exmem_flush: 1'b0, memwb_wen: 1'b1
    };
    localparam latch_ctrl_t CTRL_OFF = '0;

    // True when any latch is frozen or bubbled this cycle.
    function automatic logic any_stall(input latch_ctrl_t c);
        return !c.pc_wen || !c.ifid_wen || !c.idex_wen || !c.exmem_wen || !c.memwb_wen
            || c.ifid_flush || c.idex_flush || c.exmem_flush;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Port bundle for the hazard controller, with a controller-side and a bench-side view.
interface hazard_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic CLK,
    input logic nRST
);
    logic             ihit;
    logic             dhit;
    regbits_t         ifid_rs;
    regbits_t         ifid_rt;
    regbits_t         idex_rt;
    logic             idex_dMemREN;
    logic             ex_redirect;
    logic             exmem_dMemREN;
    logic             exmem_dMemWEN;
    logic             memwb_halt;
    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_flush;
    logic             exmem_wen;
    logic             exmem_flush;
    logic             memwb_wen;
    logic             halted;
    hazard_state_t    state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hazard (
        input  CLK, nRST, ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dMemREN,
               ex_redirect, exmem_dMemREN, exmem_dMemWEN, memwb_halt,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
               exmem_flush, memwb_wen, halted, state, stall_cnt, flush_cnt
    );

    modport tb (
        input  CLK, nRST, pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
               exmem_flush, memwb_wen, halted, state, stall_cnt, flush_cnt,
        output ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dMemREN,
               ex_redirect, exmem_dMemREN, exmem_dMemWEN, memwb_halt
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives latch write-enables/flushes and the PC write enable,
// tracks halt, and keeps saturating stall/flush counters for performance debug.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_dMemREN,
    input  logic             ex_redirect,
    input  logic             exmem_dMemREN,
    input  logic             exmem_dMemWEN,
    input  logic             memwb_halt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             exmem_flush,
    output logic             memwb_wen,
    output logic             halted,
    output hazard_state_t    state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    hazard_state_t state_q;
    hazard_state_t state_d;
    latch_ctrl_t   ctrl;
    logic          mem_wait;
    logic          load_use;
    logic          stall_inc;
    logic          flush_inc;

    assign mem_wait = (exmem_dMemREN || exmem_dMemWEN) && !dhit;
    // A load targeting $0 produces nothing a consumer could wait for.
    assign load_use = idex_dMemREN && (idex_rt != '0)
                   && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = RUN;
        halted    = 1'b0;
        flush_inc = 1'b0;

        if (state_q == HALTED) begin
            ctrl    = CTRL_OFF;
            state_d = HALTED;
            halted  = 1'b1;
        end else if (memwb_halt) begin
            state_d = HALTED;
        end else if (mem_wait) begin
            ctrl    = CTRL_OFF;
            state_d = MEM_WAIT;
        end else if (ex_redirect) begin
            ctrl.ifid_wen   = 1'b0;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_wen   = 1'b0;
            ctrl.idex_flush = 1'b1;
            flush_inc       = 1'b1;
        end else if (load_use) begin
            ctrl.pc_wen     = 1'b0;
            ctrl.ifid_wen   = 1'b0;
            ctrl.idex_wen   = 1'b0;
            ctrl.idex_flush = 1'b1;
            state_d         = LU_STALL;
        end else if (!ihit) begin
            ctrl.pc_wen     = 1'b0;
            ctrl.ifid_wen   = 1'b0;
            ctrl.ifid_flush = 1'b1;
        end

        stall_inc = (state_q != HALTED) && any_stall(ctrl);

        // Latches stay frozen while reset is held.
        if (!nRST) begin
            ctrl   = CTRL_OFF;
            halted = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_wen      = ctrl.pc_wen;
    assign ifid_wen    = ctrl.ifid_wen;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_wen    = ctrl.idex_wen;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_wen   = ctrl.exmem_wen;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_wen   = ctrl.memwb_wen;
    assign state       = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
